regfile_arbiter: RTL

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_pkg.sv | 24 ++
 rtl/regfile_arbiter_if.sv | 40 ++++
 rtl/rr_lock_picker.sv | 65 ++++++
 rtl/regfile_arbiter.sv | 71 +++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared types and sizing for the two-port register-file arbiter.
// Holds the FSM encoding, index/data widths and the default burst limit.
package regfile_arbiter_pkg;

    localparam int REG_IDX_W        = 3;
    localparam int DATA_W           = 16;
    localparam int HOLD_MAX_DEFAULT = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;

    // State remembers which port was granted most recently.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    // Counter width able to hold the value HOLD_MAX itself.
    function automatic int hold_width(input int hold_max);
        return (hold_max < 1) ? 1 : $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// Bundle of requester ports, read-back path and register-file drive signals.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface regfile_arbiter_if;
    import regfile_arbiter_pkg::*;

    logic     reqA, reqB;
    logic     lockA, lockB;
    reg_idx_t aRead1, aRead2, bRead1, bRead2;
    logic     aWrite, bWrite;
    reg_idx_t aWriteReg, bWriteReg;
    data_t    aWriteData, bWriteData;

    logic     gntA, gntB;
    logic     validA, validB;
    data_t    rdData1, rdData2;

    reg_idx_t rfReadReg1, rfReadReg2, rfWriteReg;
    data_t    rfWriteFile;
    logic     rfRegWrite;
    data_t    rfReadData1, rfReadData2;

    modport slave (
        input  reqA, reqB, lockA, lockB,
        input  aRead1, aRead2, bRead1, bRead2,
        input  aWrite, bWrite, aWriteReg, bWriteReg, aWriteData, bWriteData,
        output gntA, gntB, validA, validB, rdData1, rdData2,
        output rfReadReg1, rfReadReg2, rfWriteReg, rfWriteFile, rfRegWrite,
        input  rfReadData1, rfReadData2
    );

    modport master (
        output reqA, reqB, lockA, lockB,
        output aRead1, aRead2, bRead1, bRead2,
        output aWrite, bWrite, aWriteReg, bWriteReg, aWriteData, bWriteData,
        input  gntA, gntB, validA, validB, rdData1, rdData2,
        input  rfReadReg1, rfReadReg2, rfWriteReg, rfWriteFile, rfRegWrite,
        output rfReadData1, rfReadData2
    );

endinterface

// File: rtl/rr_lock_picker.sv
// Grant decision for two requesters: round-robin on contention, with a
// bounded lock that lets the current owner keep the port for a burst.
module rr_lock_picker
    import regfile_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic lock_a,
    input  logic lock_b,
    output logic gnt_a,
    output logic gnt_b
);

    localparam int                HOLD_W     = hold_width(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);

    arb_state_t        state_reg;
    logic [HOLD_W-1:0] hold_count_reg;
    logic              owner_locked_reg;

    logic              hold_ok;
    logic              pick_b;
    logic [HOLD_W-1:0] hold_bump;

    always_comb begin
        hold_ok   = owner_locked_reg && (hold_count_reg < HOLD_LIMIT);
        // Saturate so a lone requester streaming forever cannot wrap the count.
        hold_bump = (hold_count_reg < HOLD_LIMIT) ? hold_count_reg + 1'b1 : hold_count_reg;
        pick_b    = req_b;
        if (req_a && req_b) begin
            case (state_reg)
                OWN_A:   pick_b = !hold_ok;
                OWN_B:   pick_b = hold_ok;
                default: pick_b = 1'b0;
            endcase
        end
        gnt_a = !reset && req_a && !pick_b;
        gnt_b = !reset && req_b && pick_b;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            hold_count_reg   <= '0;
            owner_locked_reg <= 1'b0;
        end else if (gnt_a) begin
            state_reg        <= OWN_A;
            hold_count_reg   <= (state_reg == OWN_A) ? hold_bump : HOLD_W'(1);
            owner_locked_reg <= lock_a;
        end else if (gnt_b) begin
            state_reg        <= OWN_B;
            hold_count_reg   <= (state_reg == OWN_B) ? hold_bump : HOLD_W'(1);
            owner_locked_reg <= lock_b;
        end else begin
            state_reg        <= IDLE;
            hold_count_reg   <= '0;
            owner_locked_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register file between a core port (A) and a debug port (B):
// routes the granted port's fields to the file and tags read-back with a valid.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    regfile_arbiter_if.slave bus
);

    logic gnt_a;
    logic gnt_b;
    logic valid_a_reg;
    logic valid_b_reg;

    rr_lock_picker #(
        .HOLD_MAX (HOLD_MAX)
    ) u_picker (
        .clock  (clock),
        .reset  (reset),
        .req_a  (bus.reqA),
        .req_b  (bus.reqB),
        .lock_a (bus.lockA),
        .lock_b (bus.lockB),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    assign bus.gntA = gnt_a;
    assign bus.gntB = gnt_b;

    always_comb begin
        bus.rfReadReg1  = '0;
        bus.rfReadReg2  = '0;
        bus.rfWriteReg  = '0;
        bus.rfWriteFile = '0;
        bus.rfRegWrite  = 1'b0;
        if (gnt_a) begin
            bus.rfReadReg1  = bus.aRead1;
            bus.rfReadReg2  = bus.aRead2;
            bus.rfWriteReg  = bus.aWriteReg;
            bus.rfWriteFile = bus.aWriteData;
            bus.rfRegWrite  = bus.aWrite;
        end else if (gnt_b) begin
            bus.rfReadReg1  = bus.bRead1;
            bus.rfReadReg2  = bus.bRead2;
            bus.rfWriteReg  = bus.bWriteReg;
            bus.rfWriteFile = bus.bWriteData;
            bus.rfRegWrite  = bus.bWrite;
        end
    end

    // Valid tracks the register file's one-cycle read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_a_reg <= 1'b0;
            valid_b_reg <= 1'b0;
        end else begin
            valid_a_reg <= gnt_a;
            valid_b_reg <= gnt_b;
        end
    end

    assign bus.validA  = valid_a_reg;
    assign bus.validB  = valid_b_reg;
    assign bus.rdData1 = bus.rfReadData1;
    assign bus.rdData2 = bus.rfReadData2;

endmodule
